// File: rtl/potential_decay_unit.sv
// Neuron potential decay sequencer: walks every stored fp32 potential, scales it by 2^-k,
// hands it to the adder stage and writes back the returned potential and spike bit.
module potential_decay_unit #(
  parameter int NUM_NEURONS = 4,
  parameter int IDX_W       = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic [2:0]             i_decay_shift,
  input  logic                   i_load_en,
  input  logic [IDX_W-1:0]       i_load_idx,
  input  logic [31:0]            i_load_value,
  output logic [31:0]            o_decayed_potential,
  output logic [IDX_W-1:0]       o_neuron_idx,
  output logic                   o_dp_valid,
  input  logic                   i_dp_ready,
  input  logic [31:0]            i_final_potential,
  input  logic                   i_spike_in,
  input  logic                   i_fp_valid,
  output logic [NUM_NEURONS-1:0] o_spike_vec,
  output logic                   o_busy,
  output logic                   o_done
);

  // state  | meaning
  // IDLE   | waiting for start, accepts potential loads
  // DECAY  | registers decayed potential of neuron idx
  // ISSUE  | presents decayed potential until the adder accepts it
  // WAIT   | waits for the adder result of neuron idx
  // DONE   | one-cycle end-of-timestep pulse
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DECAY = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [31:0]            r_pot [NUM_NEURONS];
  logic [31:0]            r_decayed;
  logic [IDX_W-1:0]       r_neuron_idx;
  logic                   r_dp_valid;
  logic [NUM_NEURONS-1:0] r_spike_vec;

  // Exponent-only scaling; anything that would go subnormal is flushed to +0.
  function automatic logic [31:0] decay_fp32(input logic [31:0] x, input logic [2:0] k);
    logic [7:0] e;
    e = x[30:23];
    if (e == 8'hFF)
      return x;
    else if (e <= {5'd0, k})
      return 32'h0000_0000;
    else
      return {x[31], e - {5'd0, k}, x[22:0]};
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= 32'h0000_0000;
      r_decayed    <= 32'h0000_0000;
      r_neuron_idx <= '0;
      r_dp_valid   <= 1'b0;
      r_spike_vec  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_load_en) begin
            r_pot[i_load_idx] <= i_load_value;
          end else if (i_start) begin
            r_state     <= S_DECAY;
            r_idx       <= '0;
            r_spike_vec <= '0;
          end
        end
        S_DECAY: begin
          r_decayed    <= decay_fp32(r_pot[r_idx], i_decay_shift);
          r_neuron_idx <= r_idx;
          r_state      <= S_ISSUE;
        end
        S_ISSUE: begin
          // valid is raised one cycle after the data lands, then held until accepted
          if (r_dp_valid && i_dp_ready) begin
            r_dp_valid <= 1'b0;
            r_state    <= S_WAIT;
          end else begin
            r_dp_valid <= 1'b1;
          end
        end
        S_WAIT: begin
          if (i_fp_valid) begin
            r_pot[r_idx]       <= i_final_potential;
            r_spike_vec[r_idx] <= i_spike_in;
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_DECAY;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_decayed_potential = r_decayed;
  assign o_neuron_idx        = r_neuron_idx;
  assign o_dp_valid          = r_dp_valid;
  assign o_spike_vec         = r_spike_vec;
  assign o_busy              = (r_state != S_IDLE);
  assign o_done              = (r_state == S_DONE);

endmodule

// File: tb/tb_potential_decay_unit.sv
// Testbench for potential_decay_unit: directed and randomized timesteps checked
// against an arithmetic reference of the stored potentials and spike bits.
module tb_potential_decay_unit;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  decay_shift;
  logic        load_en;
  logic [1:0]  load_idx;
  logic [31:0] load_value;
  logic [31:0] dec_pot;
  logic [1:0]  nidx;
  logic        dp_valid;
  logic        dp_ready;
  logic [31:0] final_pot;
  logic        spike_in;
  logic        fp_valid;
  logic [3:0]  spike_vec;
  logic        busy;
  logic        done;

  potential_decay_unit #(.NUM_NEURONS(N), .IDX_W(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_decay_shift(decay_shift),
    .i_load_en(load_en), .i_load_idx(load_idx), .i_load_value(load_value),
    .o_decayed_potential(dec_pot), .o_neuron_idx(nidx), .o_dp_valid(dp_valid),
    .i_dp_ready(dp_ready), .i_final_potential(final_pot), .i_spike_in(spike_in),
    .i_fp_valid(fp_valid), .o_spike_vec(spike_vec), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pot [N];
  logic [3:0]  m_spk;

  int          t_k  [N];
  int          t_rw [N];
  int          t_fw [N];
  logic        t_sp [N];
  logic [31:0] t_fin[N];
  int          abuse;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Multiply by 2^-k done on the raw encoding: subtract k from the exponent.
  function automatic logic [31:0] ref_decay(input logic [31:0] x, input int k);
    int e;
    e = int'(x[30:23]);
    if (e == 255) return x;
    if (e <= k) return 32'h0;
    return x - (32'(k) << 23);
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 4))
      0: v[30:23] = 8'hFF;
      1: v[30:23] = 8'($urandom_range(0, 7));
      default: ;
    endcase
    return v;
  endfunction

  // All tasks start and finish just after a falling edge.
  task automatic do_load(input int idx, input logic [31:0] val);
    load_en = 1'b1; load_idx = 2'(idx); load_value = val;
    @(negedge clk);
    load_en = 1'b0;
    m_pot[idx] = val;
  endtask

  task automatic run_ts();
    logic [31:0] held;
    decay_shift = 3'(t_k[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_spk = 4'b0;
    chk("busy_start", 32'(busy), 32'd1);
    chk("spk_clr", 32'(spike_vec), 32'(m_spk));
    for (int i = 0; i < N; i++) begin
      chk("dv_lo_a", 32'(dp_valid), 32'd0);
      @(negedge clk);
      chk("dv_lo_b", 32'(dp_valid), 32'd0);
      @(negedge clk);
      chk("dv_hi", 32'(dp_valid), 32'd1);
      held = ref_decay(m_pot[i], t_k[i]);
      chk("dec", dec_pot, held);
      chk("nidx", 32'(nidx), 32'(i));
      dp_ready = 1'b0;
      for (int c = 0; c < t_rw[i]; c++) begin
        if (i == abuse && c == 0) begin
          start = 1'b1; fp_valid = 1'b1; final_pot = $urandom; spike_in = 1'b1;
          load_en = 1'b1; load_idx = 2'(i); load_value = $urandom;
          decay_shift = 3'($urandom);
        end
        @(negedge clk);
        start = 1'b0; fp_valid = 1'b0; load_en = 1'b0; spike_in = 1'b0;
        chk("bp_dv", 32'(dp_valid), 32'd1);
        chk("bp_dec", dec_pot, held);
        chk("bp_nidx", 32'(nidx), 32'(i));
      end
      dp_ready = 1'b1;
      @(negedge clk);
      dp_ready = 1'b0;
      chk("dv_drop", 32'(dp_valid), 32'd0);
      for (int c = 0; c < t_fw[i]; c++) begin
        if (i == abuse && c == 0) begin
          start = 1'b1; load_en = 1'b1; load_idx = 2'(i); load_value = $urandom;
        end
        @(negedge clk);
        start = 1'b0; load_en = 1'b0;
        chk("wait_dv", 32'(dp_valid), 32'd0);
        chk("wait_done", 32'(done), 32'd0);
      end
      if (i + 1 < N) decay_shift = 3'(t_k[i+1]);
      final_pot = t_fin[i]; spike_in = t_sp[i]; fp_valid = 1'b1;
      @(negedge clk);
      fp_valid = 1'b0; spike_in = 1'b0;
      m_pot[i] = t_fin[i];
      m_spk[i] = t_sp[i];
    end
    chk("done_hi", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("done_lo", 32'(done), 32'd0);
    chk("busy_lo", 32'(busy), 32'd0);
    chk("spk_vec", 32'(spike_vec), 32'(m_spk));
    @(negedge clk);
    chk("done_once", 32'(done), 32'd0);
  endtask

  task automatic rand_plan();
    for (int i = 0; i < N; i++) begin
      t_k[i]   = $urandom_range(0, 7);
      t_rw[i]  = $urandom_range(0, 3);
      t_fw[i]  = $urandom_range(0, 3);
      t_sp[i]  = 1'($urandom);
      t_fin[i] = rand_fp();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; decay_shift = 3'd0; load_en = 1'b0; load_idx = 2'd0;
    load_value = 32'h0; dp_ready = 1'b0; final_pot = 32'h0; spike_in = 1'b0; fp_valid = 1'b0;
    for (int i = 0; i < N; i++) m_pot[i] = 32'h0;
    m_spk = 4'b0;
    abuse = -1;
    @(negedge clk); @(negedge clk);
    chk("rst_dec", dec_pot, 32'h0);
    chk("rst_nidx", 32'(nidx), 32'h0);
    chk("rst_dv", 32'(dp_valid), 32'h0);
    chk("rst_spk", 32'(spike_vec), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // load wins over a simultaneous start
    load_en = 1'b1; start = 1'b1; load_idx = 2'd0; load_value = 32'h4220_0000;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    m_pot[0] = 32'h4220_0000;
    chk("prio_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("prio_dv", 32'(dp_valid), 32'd0);
    do_load(1, 32'hC220_0000);
    do_load(2, 32'h0080_0000);
    do_load(3, 32'h7FC0_0000);
    chk("ref_40", ref_decay(m_pot[0], 1), 32'h41A0_0000);

    // directed timestep: backpressure, protocol abuse, spikes on 1 and 3
    t_k  = '{1, 2, 1, 0};
    t_rw = '{0, 5, 0, 2};
    t_fw = '{0, 3, 1, 0};
    t_sp = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < N; i++) t_fin[i] = rand_fp();
    abuse = 1;
    run_ts();
    chk("spk_1010", 32'(spike_vec), 32'h0000_000A);
    repeat (3) @(negedge clk);
    chk("spk_hold", 32'(spike_vec), 32'h0000_000A);

    // k=0 read-back of the written-back potentials
    t_k = '{0, 0, 0, 0}; t_rw = '{0, 1, 0, 0}; t_fw = '{1, 0, 0, 2};
    for (int i = 0; i < N; i++) begin t_sp[i] = 1'($urandom); t_fin[i] = rand_fp(); end
    abuse = 3;
    run_ts();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 1) == 1) do_load(i, rand_fp());
      rand_plan();
      abuse = $urandom_range(0, 3);
      run_ts();
    end

    // reset while waiting on the adder with fp_valid pending
    t_k = '{0, 0, 0, 0};
    decay_shift = 3'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk);
    dp_ready = 1'b1;
    @(negedge clk);
    dp_ready = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    fp_valid = 1'b1; final_pot = 32'h3F80_0000; spike_in = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("arst_dec", dec_pot, 32'h0);
    chk("arst_dv", 32'(dp_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_spk", 32'(spike_vec), 32'h0);
    @(negedge clk);
    chk("arst_done", 32'(done), 32'h0);
    rst_n = 1'b1; fp_valid = 1'b0; spike_in = 1'b0;
    for (int i = 0; i < N; i++) m_pot[i] = 32'h0;
    m_spk = 4'b0;
    @(negedge clk);
    chk("post_rst_done", 32'(done), 32'h0);
    chk("post_rst_busy", 32'(busy), 32'h0);

    rand_plan();
    abuse = -1;
    run_ts();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/potential_decay_unit.md
POTENTIAL_DECAY_UNIT -- requirements
Module: potential_decay_unit

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 4: number of neuron potentials held.
REQ-002 SHALL have parameter IDX_W, default 2: width of the neuron index, equal to clog2(NUM_NEURONS).
REQ-003 CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 RESET_N  in  1  reset; asynchronous and active-low.
REQ-005 start  in  1  begins one timestep; sampled high for one cycle.
REQ-006 decay_shift  in  3  decay factor k; the unit multiplies by 2^-k.
REQ-007 load_en / load_idx[IDX_W-1:0] / load_value[31:0]  in  initialise the stored potential of neuron load_idx.
REQ-008 decayed_potential  out  32  fp32 decayed potential fed to the potential adder.
REQ-009 neuron_idx  out  IDX_W  index of the neuron being presented.
REQ-010 dp_valid  out  1 / dp_ready  in  1  handshake towards the adder stage.
REQ-011 final_potential  in  32 / spike_in  in  1 / fp_valid  in  1  result returned by the adder stage.
REQ-012 spike_vec  out  NUM_NEURONS  spike bit per neuron for the current timestep.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse at the end of a timestep.

Function
REQ-015 SHALL hold NUM_NEURONS 32-bit potential registers, pot[i].
REQ-016 SHALL implement the FSM states IDLE, DECAY, ISSUE, WAIT and DONE.
REQ-017 IDLE: if start=1 at the edge, the FSM SHALL go to DECAY with idx=0 and spike_vec cleared to 0.
REQ-018 IDLE: if load_en=1 at the edge, pot[load_idx] SHALL be written with load_value.
REQ-019 IDLE: load_en has priority over start, so a start in the same cycle as load_en SHALL be ignored.
REQ-020 load_en SHALL be ignored in every state other than IDLE.
REQ-021 DECAY: decayed_potential SHALL be registered as decay(pot[idx], decay_shift) and neuron_idx as idx; the next state SHALL be ISSUE.
REQ-022 ISSUE: dp_valid=1; decayed_potential and neuron_idx SHALL stay stable while dp_ready=0.
REQ-023 ISSUE: a transfer SHALL occur when dp_valid=1 and dp_ready=1 at the same edge; the next state SHALL be WAIT with dp_valid=0.
REQ-024 WAIT: on fp_valid=1, pot[idx] SHALL take final_potential and spike_vec[idx] SHALL take spike_in.
REQ-025 WAIT: on fp_valid=1, if idx=NUM_NEURONS-1 the next state SHALL be DONE; otherwise idx SHALL increment and the next state SHALL be DECAY.
REQ-026 fp_valid SHALL be ignored outside WAIT.
REQ-027 DONE: done=1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 start SHALL be ignored whenever busy=1.
REQ-029 Latency: dp_valid SHALL rise 2 cycles after the edge that accepted start.
REQ-030 Latency: dp_valid for the next neuron SHALL rise 2 cycles after the accepting fp_valid edge.
REQ-031 decay() with exponent field e=x[30:23] and k=decay_shift: if e=255 (Inf/NaN), x SHALL pass through unchanged.
REQ-032 decay(): if e=0, or 0<e<=k, the result SHALL be 32'h00000000 (underflow flush).
REQ-033 decay(): otherwise the result SHALL keep the sign and mantissa with exponent e-k.
REQ-034 decay(): k=0 SHALL return x unchanged, apart from the e=0 flush of REQ-032.
REQ-035 decay_shift SHALL be sampled in DECAY only, so a mid-timestep change applies from the next neuron onward.
REQ-036 spike_vec SHALL hold its value after DONE until the next accepted start.

Reset
REQ-037 While RESET_N=0, asynchronously: FSM=IDLE, idx=0, all pot[i]=0, decayed_potential=0, neuron_idx=0, dp_valid=0, spike_vec=0, busy=0, done=0.
REQ-038 Reset during any state, including mid-handshake, SHALL abort the timestep with no done pulse; a pending fp_valid SHALL be discarded.

Verification
REQ-039 Load pot[0]=32'h42200000 (40.0), k=1, start, dp_ready=1 -> decayed_potential=32'h41A00000, neuron_idx=0, dp_valid high 2 cycles after start.
REQ-040 Load pot[1]=32'hC2200000 (-40.0), k=2 -> decayed_potential for neuron 1 = 32'hC1200000 (-10.0).
REQ-041 Flush and pass-through: pot[2]=32'h00800000 with k=1 -> decayed_potential=32'h00000000; pot[3]=32'h7FC00000 -> 32'h7FC00000.
REQ-042 Backpressure and full timestep:
- Hold dp_ready=0 for 5 cycles -> dp_valid and data stable for those cycles.
- Return spike_in=1 for neurons 1 and 3 -> spike_vec=4'b1010, done pulses once, busy=0.
- pot[] equals the returned final_potential values.
REQ-043 Protocol edge cases:
- Assert start while busy -> ignored.
- Drive fp_valid in ISSUE -> ignored.
- Assert RESET_N=0 in WAIT -> all outputs 0 immediately and no done pulse.
